// File: rtl/t02_wishbone_subordinate.sv
// Wishbone classic-cycle subordinate: word-addressed register bank behind a base-address window,
// one ACK/ERR pulse per request after WAIT_STATES idle cycles, then one recovery cycle.
module t02_wishbone_subordinate #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] Span = 32'(4 * DEPTH);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StResp    = 2'd2;
  localparam logic [1:0] StRecover = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     wdat_q;
  logic [3:0]      sel_q;
  logic            we_q, hit_q;
  logic            ack_q, ack_d, err_q, err_d;
  logic [31:0]     rdat_q, rdat_d;
  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic [31:0]     offset;
  logic            hit_in;
  logic [IdxW-1:0] idx_in;
  logic            enter_resp;

  assign req    = CYC_I & STB_I;
  assign offset = ADR_I - BASE_ADDR;
  assign hit_in = (ADR_I >= BASE_ADDR) && (offset < Span) && (ADR_I[1:0] == 2'b00);
  assign idx_in = offset[IdxW+1:2];

  // With zero wait states the response is launched from IDLE, before anything is latched.
  logic            cur_we, cur_hit;
  logic [IdxW-1:0] cur_idx;
  logic [31:0]     cur_dat;
  logic [3:0]      cur_sel;
  logic [31:0]     cur_mask;

  assign cur_we   = (state_q == StIdle) ? WE_I   : we_q;
  assign cur_hit  = (state_q == StIdle) ? hit_in : hit_q;
  assign cur_idx  = (state_q == StIdle) ? idx_in : idx_q;
  assign cur_dat  = (state_q == StIdle) ? DAT_I  : wdat_q;
  assign cur_sel  = (state_q == StIdle) ? SEL_I  : sel_q;
  assign cur_mask = {{8{cur_sel[3]}}, {8{cur_sel[2]}}, {8{cur_sel[1]}}, {8{cur_sel[0]}}};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:    state_d = StRecover;
      StRecover: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    ack_d  = enter_resp & cur_hit;
    err_d  = enter_resp & ~cur_hit;
    rdat_d = 32'h0;
    if (enter_resp && cur_hit && !cur_we) begin
      rdat_d = mem_q[cur_idx] & cur_mask;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdat_q  <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      if (state_q == StIdle && req) begin
        idx_q  <= idx_in;
        wdat_q <= DAT_I;
        sel_q  <= SEL_I;
        we_q   <= WE_I;
        hit_q  <= hit_in;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (enter_resp && cur_hit && cur_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) begin
          mem_q[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
        end
      end
    end
  end

  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign DAT_O = rdat_q;

endmodule

// File: tb/tb_t02_wishbone_subordinate.sv
// Directed bench for t02_wishbone_subordinate: three instances (0, 1 and 3 wait states) share one
// driver; dsel picks which instance sees CYC_I and whose outputs are observed.
module tb_t02_wishbone_subordinate;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'h0, dat = 32'h0;
  logic [3:0]  sel = 4'h0;
  int          dsel = 1;

  logic [31:0] dat_o [3];
  logic        ack_o [3];
  logic        err_o [3];
  logic        cur_ack, cur_err;
  logic [31:0] cur_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  t02_wishbone_subordinate #(.BASE_ADDR(Base), .DEPTH(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .nrst(nrst), .CYC_I(cyc && dsel == 0), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat), .SEL_I(sel), .DAT_O(dat_o[0]), .ACK_O(ack_o[0]), .ERR_O(err_o[0])
  );
  t02_wishbone_subordinate #(.BASE_ADDR(Base), .DEPTH(32), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .CYC_I(cyc && dsel == 1), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat), .SEL_I(sel), .DAT_O(dat_o[1]), .ACK_O(ack_o[1]), .ERR_O(err_o[1])
  );
  t02_wishbone_subordinate #(.BASE_ADDR(Base), .DEPTH(32), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .nrst(nrst), .CYC_I(cyc && dsel == 2), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat), .SEL_I(sel), .DAT_O(dat_o[2]), .ACK_O(ack_o[2]), .ERR_O(err_o[2])
  );

  always_comb begin
    cur_ack = ack_o[dsel];
    cur_err = err_o[dsel];
    cur_dat = dat_o[dsel];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and watch 8 cycles; lat is the cycle of the first response (-1 if none),
  // pulses counts every cycle with ACK or ERR high.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic r_ack,
                          output logic r_err, output logic [31:0] r_dat, output int pulses);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    lat = -1; r_ack = 1'b0; r_err = 1'b0; r_dat = 32'hx; pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (cur_ack || cur_err) begin
        pulses++;
        if (lat < 0) begin
          lat = i; r_ack = cur_ack; r_err = cur_err; r_dat = cur_dat;
          cyc = 1'b0; stb = 1'b0;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ack_o[k], err_o[k], dat_o[k]} !== 34'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got ack=%b err=%b dat=%h, required 0/0/0",
                 k, ack_o[k], err_o[k], dat_o[k]);
      end
    end
  endtask

  task automatic test_first_read();
    int lat, pulses; logic a, e; logic [31:0] d;
    dsel = 1;
    bus_xfer(1'b0, Base, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (lat !== 2 || a !== 1'b1 || e !== 1'b0 || pulses !== 1) begin
      errors++;
      $display("FAIL first_read_timing: got lat=%0d ack=%b err=%b pulses=%0d, required 2/1/0/1",
               lat, a, e, pulses);
    end
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL first_read_data: got %h, required 00000000", d);
    end
  endtask

  task automatic test_byte_lanes();
    int lat, pulses; logic a, e; logic [31:0] d;
    dsel = 1;
    bus_xfer(1'b1, Base + 32'd8, 32'hDEAD_BEEF, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (a !== 1'b1 || pulses !== 1 || d !== 32'h0) begin
      errors++; $display("FAIL write_full: got ack=%b pulses=%0d dat=%h, required 1/1/0", a, pulses, d);
    end
    bus_xfer(1'b1, Base + 32'd8, 32'h0000_1200, 4'b0010, lat, a, e, d, pulses);
    checks++;
    if (a !== 1'b1 || pulses !== 1) begin
      errors++; $display("FAIL write_lane1: got ack=%b pulses=%0d, required 1/1", a, pulses);
    end
    bus_xfer(1'b0, Base + 32'd8, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (d !== 32'hDEAD_12EF || a !== 1'b1 || pulses !== 1) begin
      errors++; $display("FAIL read_merged: got %h ack=%b pulses=%0d, required DEAD12EF/1/1", d, a, pulses);
    end
    bus_xfer(1'b1, Base + 32'd8, 32'hFFFF_FFFF, 4'b0000, lat, a, e, d, pulses);
    checks++;
    if (a !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL write_sel0_ack: got ack=%b err=%b, required 1/0", a, e);
    end
    bus_xfer(1'b0, Base + 32'd8, 32'h0, 4'b1001, lat, a, e, d, pulses);
    checks++;
    if (d !== 32'hDE00_00EF) begin
      errors++; $display("FAIL read_masked: got %h, required DE0000EF", d);
    end
  endtask

  task automatic test_errors();
    int lat, pulses; logic a, e; logic [31:0] d;
    dsel = 1;
    bus_xfer(1'b0, 32'h3000_0080, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (e !== 1'b1 || a !== 1'b0 || d !== 32'h0 || lat !== 2 || pulses !== 1) begin
      errors++;
      $display("FAIL err_past_end: got err=%b ack=%b dat=%h lat=%0d pulses=%0d, required 1/0/0/2/1",
               e, a, d, lat, pulses);
    end
    bus_xfer(1'b1, Base + 32'd2, 32'hFFFF_FFFF, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (e !== 1'b1 || a !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL err_misaligned: got err=%b ack=%b dat=%h, required 1/0/0", e, a, d);
    end
    bus_xfer(1'b0, Base - 32'd4, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (e !== 1'b1 || a !== 1'b0) begin
      errors++; $display("FAIL err_below_base: got err=%b ack=%b, required 1/0", e, a);
    end
    bus_xfer(1'b0, Base, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (d !== 32'h0 || a !== 1'b1) begin
      errors++; $display("FAIL word0_unchanged: got %h ack=%b, required 00000000/1", d, a);
    end
    bus_xfer(1'b1, Base + 32'h7C, 32'h1357_9BDF, 4'hF, lat, a, e, d, pulses);
    bus_xfer(1'b0, Base + 32'h7C, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (d !== 32'h1357_9BDF || a !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL last_word: got %h ack=%b err=%b, required 13579BDF/1/0", d, a, e);
    end
  endtask

  task automatic test_abort();
    int lat, pulses; logic a, e; logic [31:0] d;
    int seen;
    dsel = 2;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = Base + 32'd16; dat = 32'h1234_5678; sel = 4'hF;
    seen = 0;
    tick();
    if (cur_ack || cur_err) seen++;
    tick();
    stb = 1'b0; dat = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (cur_ack || cur_err) seen++;
      tick();
    end
    cyc = 1'b0; we = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_resp: got %0d pulses, required 0", seen);
    end
    bus_xfer(1'b0, Base + 32'd16, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (d !== 32'h0 || lat !== 4 || a !== 1'b1) begin
      errors++; $display("FAIL abort_no_write: got dat=%h lat=%0d ack=%b, required 0/4/1", d, lat, a);
    end
    bus_xfer(1'b1, Base + 32'd16, 32'hA5A5_A5A5, 4'hF, lat, a, e, d, pulses);
    bus_xfer(1'b0, Base + 32'd16, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (d !== 32'hA5A5_A5A5 || lat !== 4 || pulses !== 1) begin
      errors++; $display("FAIL ws3_rw: got dat=%h lat=%0d pulses=%0d, required A5A5A5A5/4/1", d, lat, pulses);
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses; logic a, e; logic [31:0] d;
    logic [8:0] mask;
    int errs;
    // Held strobe: each re-acceptance is a fresh request, so ACKs recur every WAIT_STATES+3 cycles.
    for (int k = 0; k < 2; k++) begin
      dsel = k;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base; sel = 4'hF;
      mask = '0; errs = 0;
      for (int i = 1; i <= 8; i++) begin
        tick();
        mask[i] = cur_ack;
        if (cur_err) errs++;
      end
      cyc = 1'b0; stb = 1'b0;
      tick(); tick();
      checks++;
      if (k == 0 && (mask !== 9'b0_1001_0010 || errs !== 0)) begin
        errors++; $display("FAIL held_stb_ws0: got ack cycles %b err=%0d, required 010010010/0", mask, errs);
      end
      checks++;
      if (k == 1 && (mask !== 9'b0_0100_0100 || errs !== 0)) begin
        errors++; $display("FAIL held_stb_ws1: got ack cycles %b err=%0d, required 001000100/0", mask, errs);
      end
    end
    dsel = 0;
    bus_xfer(1'b1, Base + 32'd4, 32'hCAFE_F00D, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (lat !== 1 || a !== 1'b1 || pulses !== 1) begin
      errors++; $display("FAIL ws0_write: got lat=%0d ack=%b pulses=%0d, required 1/1/1", lat, a, pulses);
    end
    bus_xfer(1'b0, Base + 32'd4, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (d !== 32'hCAFE_F00D || lat !== 1) begin
      errors++; $display("FAIL ws0_raw: got dat=%h lat=%0d, required CAFEF00D/1", d, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses; logic a, e; logic [31:0] d;
    dsel = 1;
    bus_xfer(1'b1, Base + 32'd20, 32'h55AA_55AA, 4'hF, lat, a, e, d, pulses);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base + 32'd20; sel = 4'hF;
    tick();
    tick();
    checks++;
    if (cur_ack !== 1'b1 || cur_dat !== 32'h55AA_55AA) begin
      errors++; $display("FAIL pre_reset_read: got ack=%b dat=%h, required 1/55AA55AA", cur_ack, cur_dat);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (cur_ack !== 1'b0 || cur_err !== 1'b0 || cur_dat !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_outputs: got ack=%b err=%b dat=%h, required 0/0/0", cur_ack, cur_err, cur_dat);
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    bus_xfer(1'b0, Base + 32'd20, 32'h0, 4'hF, lat, a, e, d, pulses);
    checks++;
    if (d !== 32'h0 || a !== 1'b1) begin
      errors++; $display("FAIL bank_cleared: got dat=%h ack=%b, required 00000000/1", d, a);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    nrst = 1'b1;
    tick();
    test_first_read();
    test_byte_lanes();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
